vga_timing_gen: RTL

- Parametrised VGA raster timing and pixel pipeline; the next generation of the fixed 800x600@72 (50 MHz) test-pattern generator.
- Generates HS/VS/BLANK_N from programmable timing, gated by a pixel clock enable.
- Produces built-in test patterns, or fetches pixels from an external source with a latency-compensating pipeline.
- Sits between CLOCK_50 and the VGA DAC pins; later the PPU frame buffer connects on the pixel-request port.

---
 rtl/vga_timing_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing generator with built-in test patterns and a
// latency-compensated external pixel path; all state advances on PIX_CE only.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BP      = 64,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 23,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int COLOR_W   = 8,
    parameter int PIX_LAT   = 2,
    parameter int CHK_SHIFT = 3,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL),
    localparam int CW       = 3 * COLOR_W
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               PIX_CE,
    input  logic [1:0]         MODE,
    input  logic [CW-1:0]      SOLID_RGB,
    output logic [HW-1:0]      PIX_X,
    output logic [VW-1:0]      PIX_Y,
    output logic               PIX_REQ,
    input  logic [CW-1:0]      PIX_DATA,
    output logic [COLOR_W-1:0] VGA_RED,
    output logic [COLOR_W-1:0] VGA_GREEN,
    output logic [COLOR_W-1:0] VGA_BLUE,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               FRAME_START
);

    typedef struct packed {
        logic          ext;
        logic          active;
        logic          hs_act;
        logic          vs_act;
        logic          frame0;
        logic [CW-1:0] rgb;
    } stage_t;

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [1:0]    r_mode;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last = (int'(r_h) == H_TOTAL - 1);
    assign w_v_last = (int'(r_v) == V_TOTAL - 1);

    // Mode is only latched on the last pixel of a frame so a frame never mixes patterns.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_h    <= '0;
            r_v    <= '0;
            r_mode <= 2'd0;
        end else if (PIX_CE) begin
            r_h <= w_h_last ? '0 : r_h + 1'b1;
            if (w_h_last) begin
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end
            if (w_h_last && w_v_last) begin
                r_mode <= MODE;
            end
        end
    end

    logic          w_active;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_frame0;
    logic          w_chk;
    logic [HW-1:0] w_bar_q;
    logic [2:0]    w_bar;
    logic [CW-1:0] w_pat;
    stage_t        w_s0;
    stage_t        w_tap;

    assign w_active = (int'(r_h) < H_ACTIVE) && (int'(r_v) < V_ACTIVE);
    assign w_hs_act = (int'(r_h) >= H_ACTIVE + H_FP) && (int'(r_h) < H_ACTIVE + H_FP + H_SYNC);
    assign w_vs_act = (int'(r_v) >= V_ACTIVE + V_FP) && (int'(r_v) < V_ACTIVE + V_FP + V_SYNC);
    assign w_frame0 = (r_h == '0) && (r_v == '0);
    assign w_chk    = r_h[CHK_SHIFT] ^ r_v[CHK_SHIFT];
    assign w_bar_q  = r_h / HW'(H_ACTIVE / 8);
    assign w_bar    = (w_bar_q > HW'(7)) ? 3'd7 : w_bar_q[2:0];

    always_comb begin
        w_pat = '0;
        case (r_mode)
            2'd0:    w_pat = SOLID_RGB;
            2'd1:    w_pat = {CW{w_chk}};
            2'd2:    w_pat = {{COLOR_W{w_bar[2]}}, {COLOR_W{w_bar[1]}}, {COLOR_W{w_bar[0]}}};
            default: w_pat = '0;
        endcase
    end

    // External pixels carry only a flag here; the data is merged at the delay-line tap.
    assign w_s0    = {r_mode == 2'd3, w_active, w_hs_act, w_vs_act, w_frame0, w_pat};
    assign PIX_REQ = w_active & PIX_CE & RESET_N;
    assign PIX_X   = r_h;
    assign PIX_Y   = r_v;

    if (PIX_LAT == 0) begin : g_no_delay
        assign w_tap = w_s0;
    end else begin : g_delay
        stage_t r_dl [PIX_LAT];

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                for (int i = 0; i < PIX_LAT; i++) begin
                    r_dl[i] <= '0;
                end
            end else if (PIX_CE) begin
                r_dl[0] <= w_s0;
                for (int i = 1; i < PIX_LAT; i++) begin
                    r_dl[i] <= r_dl[i-1];
                end
            end
        end

        assign w_tap = r_dl[PIX_LAT-1];
    end

    logic [CW-1:0] w_out_rgb;
    logic [CW-1:0] r_rgb;
    logic          r_blank_n;
    logic          r_hs;
    logic          r_vs;
    logic          r_fs;

    assign w_out_rgb = w_tap.ext ? PIX_DATA : w_tap.rgb;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rgb     <= '0;
            r_blank_n <= 1'b0;
            r_hs      <= ~HS_POL;
            r_vs      <= ~VS_POL;
            r_fs      <= 1'b0;
        end else if (PIX_CE) begin
            r_rgb     <= w_tap.active ? w_out_rgb : '0;
            r_blank_n <= w_tap.active;
            r_hs      <= w_tap.hs_act ? HS_POL : ~HS_POL;
            r_vs      <= w_tap.vs_act ? VS_POL : ~VS_POL;
            r_fs      <= w_tap.frame0;
        end
    end

    assign VGA_RED     = r_rgb[3*COLOR_W-1:2*COLOR_W];
    assign VGA_GREEN   = r_rgb[2*COLOR_W-1:COLOR_W];
    assign VGA_BLUE    = r_rgb[COLOR_W-1:0];
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign FRAME_START = r_fs;

endmodule
